// File: rtl/fei4_readout_pkg.sv
// ----------------------------------------------------------------------------
// fei4_readout_pkg
// Shared definitions for the FE-I4 readout path: the header-slot count,
// default counter widths and the readout sequencer state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package fei4_readout_pkg;

  localparam int L1_SLOTS = 16;  // header store depth
  localparam int LV1ID_W  = 7;   // LV1ID counter width
  localparam int SKIP_W   = 8;   // skipped-trigger counter width

  // Readout walk of one stored event: wait for a slot, present its header,
  // stream its hit data, then release the slot.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_REL  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/l1_trigger_scheduler_if.sv
// ----------------------------------------------------------------------------
// l1_trigger_scheduler_if
// Readout handshake between the trigger scheduler and the event builder.
//   L1Req        scheduler -> readout  slot of the event being read
//   HeaderValid  scheduler -> readout  header of slot L1Req is available
//   HeaderAck    readout -> scheduler  header taken
//   EventBusy    scheduler -> readout  hit data of the event being streamed
//   EventDone    readout -> scheduler  hit data finished
// Modports: master = scheduler side, slave = readout side.
// ----------------------------------------------------------------------------
interface l1_trigger_scheduler_if #(
  parameter int DEPTH_LOG2 = 4
);

  logic [DEPTH_LOG2-1:0] L1Req;
  logic                  HeaderValid;
  logic                  HeaderAck;
  logic                  EventBusy;
  logic                  EventDone;

  modport master (
    output L1Req, HeaderValid, EventBusy,
    input  HeaderAck, EventDone
  );

  modport slave (
    input  L1Req, HeaderValid, EventBusy,
    output HeaderAck, EventDone
  );

endinterface

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Width-parameterised up-counter that holds at its all-ones value.
// Only exists in builds with L1_SKIP_COUNT_EN defined.
// Ports:
//   Clk      in   clock
//   Reset    in   asynchronous active-low reset (count -> 0)
//   i_inc    in   count one event this cycle
//   o_count  out  current count, saturating at 2^WIDTH-1
// ----------------------------------------------------------------------------
`ifdef L1_SKIP_COUNT_EN
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/l1_trigger_scheduler.sv
// ----------------------------------------------------------------------------
// l1_trigger_scheduler
// Sequences the 16-slot L1 header store: hands out a write slot per accepted
// L1, keeps the LV1ID count, tracks occupancy/full/empty and walks stored
// events out to the readout in arrival order.
//
// Optional feature: define L1_SKIP_COUNT_EN to count triggers dropped while
// full (saturating). Without it SkippedCnt is tied to zero.
//
// Ports:
//   Clk           in   clock
//   Reset         in   asynchronous active-low reset
//   L1            in   trigger pulse, one cycle per trigger
//   ClearLV1Id    in   synchronous clear of the LV1ID counter
//   L1In          out  write slot for the header store
//   L1_Reg_Full   out  all slots occupied
//   L1_Reg_Empty  out  no slot occupied
//   Occupancy     out  slots in use, 0..2^DEPTH_LOG2
//   LV1Id         out  current trigger ID, stored together with L1In
//   SkippedCnt    out  triggers dropped while full
//   rd            if   readout handshake (master side): L1Req, HeaderValid,
//                      HeaderAck, EventBusy, EventDone
// ----------------------------------------------------------------------------
module l1_trigger_scheduler
  import fei4_readout_pkg::*;
#(
  parameter int DEPTH_LOG2 = $clog2(fei4_readout_pkg::L1_SLOTS),
  parameter int LV1ID_W    = fei4_readout_pkg::LV1ID_W,
  parameter int SKIP_W     = fei4_readout_pkg::SKIP_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  L1,
  input  logic                  ClearLV1Id,
  output logic [DEPTH_LOG2-1:0] L1In,
  output logic                  L1_Reg_Full,
  output logic                  L1_Reg_Empty,
  output logic [DEPTH_LOG2:0]   Occupancy,
  output logic [LV1ID_W-1:0]    LV1Id,
  output logic [SKIP_W-1:0]     SkippedCnt,
  l1_trigger_scheduler_if.master rd
);

  localparam int                SLOTS    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] OCC_FULL = (DEPTH_LOG2 + 1)'(SLOTS);

  logic [DEPTH_LOG2-1:0] r_l1in;
  logic [DEPTH_LOG2-1:0] r_l1req;
  logic [DEPTH_LOG2:0]   r_occ;
  logic                  r_full;
  logic                  r_empty;
  logic [LV1ID_W-1:0]    r_lv1id;
  rd_state_t             r_state;
  logic                  r_header_valid;
  logic                  r_event_busy;

  logic                  w_accept;
  logic                  w_release;
  logic [DEPTH_LOG2:0]   w_occ_next;

  // The registered Full flag gates acceptance, so a slot freed in the same
  // cycle cannot be reused by a coincident trigger.
  assign w_accept  = L1 & ~r_full;
  assign w_release = (r_state == ST_REL);

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_occ_next = r_occ;
    if (w_accept && !w_release) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_accept && w_release) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  // Write side: slot pointer, occupancy and trigger ID.
  // Full/Empty come from the occupancy count; the pointers alone cannot tell
  // a full store from an empty one because they wrap silently.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_l1in  <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_lv1id <= '0;
    end else begin
      if (w_accept) begin
        r_l1in <= r_l1in + 1'b1;
      end
      r_occ   <= w_occ_next;
      r_full  <= (w_occ_next == OCC_FULL);
      r_empty <= (w_occ_next == '0);
      // Every trigger consumes an ID, dropped ones included, so gaps in the
      // stored IDs expose lost events; the clear takes priority.
      if (ClearLV1Id) begin
        r_lv1id <= '0;
      end else if (L1) begin
        r_lv1id <= r_lv1id + 1'b1;
      end
    end
  end

  // Read side: one event per pass IDLE -> HDR -> DATA -> REL. HeaderValid
  // and EventBusy are registered alongside the state they belong to.
  // An ack while in HDR wins over a coincident EventDone, which is only
  // looked at in DATA.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state        <= ST_IDLE;
      r_l1req        <= '0;
      r_header_valid <= 1'b0;
      r_event_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_empty) begin
            r_state        <= ST_HDR;
            r_header_valid <= 1'b1;
          end
        end
        ST_HDR: begin
          if (rd.HeaderAck) begin
            r_state        <= ST_DATA;
            r_header_valid <= 1'b0;
            r_event_busy   <= 1'b1;
          end
        end
        ST_DATA: begin
          if (rd.EventDone) begin
            r_state      <= ST_REL;
            r_event_busy <= 1'b0;
          end
        end
        ST_REL: begin
          r_state <= ST_IDLE;
          r_l1req <= r_l1req + 1'b1;
        end
        default: begin
          r_state        <= ST_IDLE;
          r_header_valid <= 1'b0;
          r_event_busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef L1_SKIP_COUNT_EN
  sat_counter #(
    .WIDTH (SKIP_W)
  ) u_skip_cnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_inc   (L1 & r_full),
    .o_count (SkippedCnt)
  );
`else
  assign SkippedCnt = '0;
`endif

  assign L1In           = r_l1in;
  assign L1_Reg_Full    = r_full;
  assign L1_Reg_Empty   = r_empty;
  assign Occupancy      = r_occ;
  assign LV1Id          = r_lv1id;
  assign rd.L1Req       = r_l1req;
  assign rd.HeaderValid = r_header_valid;
  assign rd.EventBusy   = r_event_busy;

endmodule

// File: tb/tb_l1_trigger_scheduler.sv
// ----------------------------------------------------------------------------
// tb_l1_trigger_scheduler
// Drives triggers and the readout handshake into l1_trigger_scheduler.
// A transaction-level model (slot counters, occupancy count, ID counter and a
// queue of expected events) predicts the scheduler outputs; a monitor pops
// the queue each time a header is presented and compares slot and stored ID.
// Honours L1_SKIP_COUNT_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_l1_trigger_scheduler;

  localparam int SLOTS    = 16;
  localparam int ID_MOD   = 128;
  localparam int SKIP_MAX = 255;

  typedef struct {
    int slot;
    int id;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       L1;
  logic       ClearLV1Id;
  logic [3:0] L1In;
  logic       L1_Reg_Full;
  logic       L1_Reg_Empty;
  logic [4:0] Occupancy;
  logic [6:0] LV1Id;
  logic [7:0] SkippedCnt;

  l1_trigger_scheduler_if #(.DEPTH_LOG2(4)) rd ();

  l1_trigger_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .L1           (L1),
    .ClearLV1Id   (ClearLV1Id),
    .L1In         (L1In),
    .L1_Reg_Full  (L1_Reg_Full),
    .L1_Reg_Empty (L1_Reg_Empty),
    .Occupancy    (Occupancy),
    .LV1Id        (LV1Id),
    .SkippedCnt   (SkippedCnt),
    .rd           (rd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  int   m_wr, m_rd, m_occ, m_id, m_skip;
  bit   rel_pending;
  exp_t exp_q[$];
  logic [6:0] store [SLOTS];  // header store as the real one would fill it

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_state();
    check("l1in",      32'(L1In),         32'(m_wr));
    check("l1req",     32'(rd.L1Req),     32'(m_rd));
    check("occupancy", 32'(Occupancy),    32'(m_occ));
    check("full",      32'(L1_Reg_Full),  32'(m_occ == SLOTS));
    check("empty",     32'(L1_Reg_Empty), 32'(m_occ == 0));
    check("lv1id",     32'(LV1Id),        32'(m_id));
    check("skipped",   32'(SkippedCnt),   32'(m_skip));
  endtask

  // One clock: called at a falling edge, drives inputs for the next rising
  // edge, advances the model, returns at the following falling edge.
  task automatic step(input bit l1, input bit clr, input bit ack, input bit done);
    bit rel_now, acc;
    if (l1 && !L1_Reg_Full) store[L1In] = LV1Id;
    // Done seen while busy -> REL next cycle -> slot freed one edge later.
    rel_now     = rel_pending;
    rel_pending = done && rd.EventBusy;
    L1 = l1; ClearLV1Id = clr; rd.HeaderAck = ack; rd.EventDone = done;
    acc = l1 && (m_occ < SLOTS);
    if (acc) begin
      exp_q.push_back('{m_wr, m_id});
      m_wr = (m_wr + 1) % SLOTS;
    end
`ifdef L1_SKIP_COUNT_EN
    if (l1 && !acc && m_skip < SKIP_MAX) m_skip++;
`endif
    if (clr) m_id = 0;
    else if (l1) m_id = (m_id + 1) % ID_MOD;
    m_occ = m_occ + int'(acc) - int'(rel_now);
    if (rel_now) m_rd = (m_rd + 1) % SLOTS;
    @(posedge Clk);
    @(negedge Clk);
    check_state();
  endtask

  // Readout that acks every header and finishes every event at once.
  task automatic step_rd(input bit l1);
    step(l1, 1'b0, rd.HeaderValid, rd.EventBusy);
  endtask

  task automatic do_reset(input string tag);
    #3;
    Reset = 1'b0;
    L1 = 1'b0; ClearLV1Id = 1'b0; rd.HeaderAck = 1'b0; rd.EventDone = 1'b0;
    m_wr = 0; m_rd = 0; m_occ = 0; m_id = 0; m_skip = 0;
    rel_pending = 1'b0;
    exp_q.delete();
    #1;  // still before the next rising edge
    check({tag, "_l1in"},  32'(L1In),           0);
    check({tag, "_l1req"}, 32'(rd.L1Req),       0);
    check({tag, "_occ"},   32'(Occupancy),      0);
    check({tag, "_empty"}, 32'(L1_Reg_Empty),   1);
    check({tag, "_full"},  32'(L1_Reg_Full),    0);
    check({tag, "_lv1id"}, 32'(LV1Id),          0);
    check({tag, "_hv"},    32'(rd.HeaderValid), 0);
    check({tag, "_busy"},  32'(rd.EventBusy),   0);
    check({tag, "_skip"},  32'(SkippedCnt),     0);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && m_occ != 0; i++) step_rd(1'b0);
    check({tag, "_drained"},  32'(m_occ), 0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
  endtask

  // Scoreboard monitor: every new header presentation consumes one expected event.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      #1;
      if (Reset && rd.HeaderValid && !prev) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_pop: header for slot %0d presented, expected no event", rd.L1Req);
        end else begin
          e = exp_q.pop_front();
          check("sb_slot",  32'(rd.L1Req),        32'(e.slot));
          check("sb_lv1id", 32'(store[rd.L1Req]), 32'(e.id));
        end
      end
      prev = rd.HeaderValid;
    end
  end

  initial begin
    Reset = 1'b0;
    L1 = 1'b0; ClearLV1Id = 1'b0; rd.HeaderAck = 1'b0; rd.EventDone = 1'b0;
    @(negedge Clk);
    do_reset("t1_rst");

    // Single event with latency and release
    step(1, 0, 0, 0);
    check("t2_l1in",  32'(L1In), 1);
    check("t2_lv1id", 32'(LV1Id), 1);
    check("t2_occ",   32'(Occupancy), 1);
    check("t2_hv_early", 32'(rd.HeaderValid), 0);
    step(0, 0, 0, 0);
    check("t2_hv",    32'(rd.HeaderValid), 1);
    check("t2_l1req", 32'(rd.L1Req), 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t2_l1req_rel", 32'(rd.L1Req), 1);
    check("t2_empty",     32'(L1_Reg_Empty), 1);

    // Reset in the middle of DATA
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("rst_mid_busy", 32'(rd.EventBusy), 1);
    do_reset("rst_mid");

    // Fill to full, reject the 17th
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    check("t3_full",  32'(L1_Reg_Full), 1);
    check("t3_wrap",  32'(L1In), 0);
    step(1, 0, 0, 0);
    check("t3_l1in",  32'(L1In), 0);
    check("t3_occ",   32'(Occupancy), 16);
    check("t3_lv1id", 32'(LV1Id), 17);
`ifdef L1_SKIP_COUNT_EN
    check("t3_skip",  32'(SkippedCnt), 1);
`else
    check("t3_skip",  32'(SkippedCnt), 0);
`endif
    // Full with a trigger in the release cycle: still rejected
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("t6_occ",  32'(Occupancy), 15);
    check("t6_l1in", 32'(L1In), 0);
`ifdef L1_SKIP_COUNT_EN
    check("t6_skip", 32'(SkippedCnt), 2);
`else
    check("t6_skip", 32'(SkippedCnt), 0);
`endif
    step(1, 0, 0, 0);
    check("t6_occ_next",  32'(Occupancy), 16);
    check("t6_l1in_next", 32'(L1In), 1);
    drain("t6");

    // Accept and release in the same cycle
    do_reset("t4_rst");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("t4_occ",   32'(Occupancy), 5);
    check("t4_l1in",  32'(L1In), 6);
    check("t4_l1req", 32'(rd.L1Req), 1);
    drain("t4");

    // LV1Id wrap and skip counter saturation
    do_reset("t5_rst");
    for (int i = 0; i < 127; i++) step(1, 0, 0, 0);
    check("t5_id127", 32'(LV1Id), 127);
    step(1, 0, 0, 0);
    check("t5_id_wrap", 32'(LV1Id), 0);
    for (int i = 0; i < 150; i++) step(1, 0, 0, 0);
`ifdef L1_SKIP_COUNT_EN
    check("t5_skip_sat", 32'(SkippedCnt), SKIP_MAX);
`else
    check("t5_skip_off", 32'(SkippedCnt), 0);
`endif
    drain("t5_wrap");

    // Clear coincident with an accepted trigger
    do_reset("t5c_rst");
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    check("t5c_id9", 32'(LV1Id), 9);
    step(1, 1, 0, 0);
    check("t5c_lv1id", 32'(LV1Id), 0);
    check("t5c_store", 32'(store[9]), 9);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("t5c_lv1id_after", 32'(LV1Id), 1);
    drain("t5c");

    // Randomised traffic, including stray acks/dones outside their states
    do_reset("rnd_rst");
    for (int i = 0; i < 2000; i++) begin
      bit l1, clr, ack, done;
      l1   = ($urandom % 100) < 45;
      clr  = ($urandom % 100) < 3;
      ack  = rd.HeaderValid ? (($urandom % 100) < 60) : (($urandom % 100) < 10);
      done = rd.EventBusy   ? (($urandom % 100) < 50) : (($urandom % 100) < 10);
      step(l1, clr, ack, done);
    end
    drain("rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
